// File: rtl/corelet_ctrl.sv
// rtl/corelet_ctrl.sv - per-layer instruction sequencer driving the corelet 34-bit inst bus
module corelet_ctrl #(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int addr_bw = 11,
    parameter int cnt_bw  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [cnt_bw-1:0]  n_x,
    input  logic [cnt_bw-1:0]  n_k,
    input  logic [addr_bw-1:0] w_base,
    input  logic [addr_bw-1:0] x_base,
    input  logic [addr_bw-1:0] p_base,
    input  logic               l0_o_full,
    input  logic               ofifo_o_valid,
    output logic [33:0]        inst,
    output logic               busy,
    output logic               done
);

    localparam logic [33:0] IDLE_WORD = 34'h1_0008_0000;
    localparam int FL = row + col;
    localparam int CW = (cnt_bw > $clog2(FL + 1)) ? cnt_bw : $clog2(FL + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_LDW, S_KLD, S_KFL, S_LDX, S_EXE, S_EFL, S_DRN, S_DONE
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [cnt_bw-1:0]  k;
    logic [cnt_bw-1:0]  n_x_q;
    logic [cnt_bw-1:0]  n_k_q;
    logic [addr_bw-1:0] w_addr;
    logic [addr_bw-1:0] x_base_q;
    logic [addr_bw-1:0] x_addr;
    logic [addr_bw-1:0] p_addr;
    logic               rd_pend;

    // xmem has one cycle of read latency, so the word read last cycle is written to L0 now
    assign rd_pend = ~inst[19];

    function automatic logic [33:0] ld_word(input logic rd, input logic [addr_bw-1:0] a,
                                            input logic wr);
        logic [33:0] w;
        w = IDLE_WORD;
        if (rd) begin
            w[19]   = 1'b0;
            w[18]   = 1'b1;
            w[17:7] = 11'(a);
        end
        w[2] = wr;
        return w;
    endfunction

    function automatic logic [33:0] pm_word(input logic [addr_bw-1:0] a);
        logic [33:0] w;
        w        = IDLE_WORD;
        w[32]    = 1'b0;
        w[31]    = 1'b0;
        w[30:20] = 11'(a);
        w[6]     = 1'b1;
        return w;
    endfunction

    function automatic logic [33:0] arr_word(input logic exe);
        logic [33:0] w;
        w    = IDLE_WORD;
        w[3] = 1'b1;
        w[1] = exe;
        w[0] = ~exe;
        return w;
    endfunction

    // inst holds the word decided in the previous cycle; each state decides the next word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            inst     <= IDLE_WORD;
            busy     <= 1'b0;
            done     <= 1'b0;
            cnt      <= '0;
            k        <= '0;
            n_x_q    <= '0;
            n_k_q    <= '0;
            w_addr   <= '0;
            x_base_q <= '0;
            x_addr   <= '0;
            p_addr   <= '0;
        end else begin
            inst <= IDLE_WORD;
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        n_x_q    <= n_x;
                        n_k_q    <= n_k;
                        w_addr   <= w_base;
                        x_base_q <= x_base;
                        p_addr   <= p_base;
                        k        <= '0;
                        cnt      <= '0;
                        state    <= S_LDW;
                    end
                end
                S_LDW: begin
                    if (cnt == CW'(row)) begin
                        inst  <= ld_word(1'b0, w_addr, rd_pend);
                        cnt   <= '0;
                        state <= S_KLD;
                    end else begin
                        inst <= ld_word(~l0_o_full, w_addr, rd_pend);
                        if (!l0_o_full) begin
                            w_addr <= w_addr + addr_bw'(1);
                            cnt    <= cnt + CW'(1);
                        end
                    end
                end
                S_KLD: begin
                    inst <= arr_word(1'b0);
                    if (cnt == CW'(col - 1)) begin
                        cnt   <= '0;
                        state <= S_KFL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_KFL: begin
                    if (cnt == CW'(FL - 1)) begin
                        cnt    <= '0;
                        x_addr <= x_base_q;
                        state  <= S_LDX;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_LDX: begin
                    if (cnt == CW'(n_x_q)) begin
                        inst  <= ld_word(1'b0, x_addr, rd_pend);
                        cnt   <= '0;
                        state <= S_EXE;
                    end else begin
                        inst <= ld_word(~l0_o_full, x_addr, rd_pend);
                        if (!l0_o_full) begin
                            x_addr <= x_addr + addr_bw'(1);
                            cnt    <= cnt + CW'(1);
                        end
                    end
                end
                S_EXE: begin
                    inst <= arr_word(1'b1);
                    if (cnt == CW'(n_x_q) - CW'(1)) begin
                        cnt   <= '0;
                        state <= S_EFL;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_EFL: begin
                    if (cnt == CW'(FL - 1)) begin
                        cnt   <= '0;
                        state <= S_DRN;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                S_DRN: begin
                    // psums for pass k land contiguously after pass k-1, so p_addr just runs on
                    if (ofifo_o_valid) begin
                        inst   <= pm_word(p_addr);
                        p_addr <= p_addr + addr_bw'(1);
                        if (cnt == CW'(n_x_q) - CW'(1)) begin
                            cnt   <= '0;
                            k     <= k + cnt_bw'(1);
                            state <= (k == n_k_q - cnt_bw'(1)) ? S_DONE : S_LDW;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
